// File: rtl/map_pkg.sv
// Shared types for the writable tile map: block/hit encodings, tile record and
// the default layout generator used while the map is being (re)built.
package map_pkg;

    typedef enum logic [2:0] {
        BT_BRICK = 3'd0,
        BT_WALL  = 3'd1,
        BT_TREE  = 3'd2,
        BT_WATER = 3'd3,
        BT_AIR   = 3'd7
    } block_type_e;

    typedef enum logic [1:0] {
        HR_PASS    = 2'd0,
        HR_ABSORB  = 2'd1,
        HR_DESTROY = 2'd2
    } hit_result_e;

    localparam int TILE_STATE_W = 4;

    typedef struct packed {
        block_type_e               btype;
        logic [TILE_STATE_W-1:0]   state;
    } tile_t;

    // Centre row carries the side walls and two brick pairs; the rows either
    // side of it plus the outer rows are open lanes.
    function automatic tile_t default_tile(input int x, input int y, input int map_w, input int map_h);
        tile_t t;
        int    mid;
        mid     = map_h / 2;
        t.state = {TILE_STATE_W{1'b1}};
        if (y == 0 || y == mid - 1 || y == mid + 1 || y == map_h - 1) begin
            t.btype = BT_AIR;
        end else if (y == mid) begin
            if (x == 0 || x == map_w - 1) begin
                t.btype = BT_WALL;
            end else if (x == 2 || x == 3 || x == map_w - 4 || x == map_w - 3) begin
                t.btype = BT_BRICK;
            end else begin
                t.btype = BT_AIR;
            end
        end else if (x[0]) begin
            t.btype = BT_BRICK;
        end else begin
            t.btype = BT_AIR;
        end
        return t;
    endfunction

endpackage

// File: rtl/map_init_seq.sv
// Raster-order walker used while the map is rebuilt: presents one tile
// coordinate and its default contents per step, x fastest.
module map_init_seq
    import map_pkg::*;
#(
    parameter int MAP_W   = 13,
    parameter int MAP_H   = 13,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output tile_t              tile,
    output logic               last
);

    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;

    // Raster counter; wraps to the origin after the final tile
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= {COORD_W{1'b0}};
            y_r <= {COORD_W{1'b0}};
        end else if (clear) begin
            x_r <= {COORD_W{1'b0}};
            y_r <= {COORD_W{1'b0}};
        end else if (step) begin
            if (int'(x_r) == MAP_W - 1) begin
                x_r <= {COORD_W{1'b0}};
                if (int'(y_r) == MAP_H - 1) begin
                    y_r <= {COORD_W{1'b0}};
                end else begin
                    y_r <= y_r + 1'b1;
                end
            end else begin
                x_r <= x_r + 1'b1;
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    // Default contents and end-of-map flag for the current position
    always_comb begin
        tile = default_tile(int'(x_r), int'(y_r), MAP_W, MAP_H);
        last = step && (int'(x_r) == MAP_W - 1) && (int'(y_r) == MAP_H - 1);
    end

    assign x = x_r;
    assign y = y_r;

endmodule

// File: rtl/map_tile_ram.sv
// Writable tile map with N_RD registered read channels and a read-modify-write
// damage port. The damage port exists only when MAP_DAMAGE_EN is defined.
module map_tile_ram
    import map_pkg::*;
#(
    parameter int MAP_W   = 13,
    parameter int MAP_H   = 13,
    parameter int COORD_W = 4,
    parameter int STATE_W = 4,
    parameter int N_RD    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      reload_i,
    output logic                      ready_o,
    input  logic [N_RD-1:0]           rd_en_i,
    input  logic [N_RD*COORD_W-1:0]   rd_x_i,
    input  logic [N_RD*COORD_W-1:0]   rd_y_i,
    output logic [N_RD*3-1:0]         rd_type_o,
    output logic [N_RD*STATE_W-1:0]   rd_state_o,
    input  logic                      hit_valid_i,
    input  logic [COORD_W-1:0]        hit_x_i,
    input  logic [COORD_W-1:0]        hit_y_i,
    output logic                      hit_ready_o,
    output logic                      hit_done_o,
    output logic [1:0]                hit_result_o
);

    localparam int N_TILES = MAP_W * MAP_H;
    localparam int ADDR_W  = $clog2(N_TILES);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
`ifdef MAP_DAMAGE_EN
    localparam logic [1:0] ST_HIT_RD = 2'd2;
    localparam logic [1:0] ST_HIT_WR = 2'd3;
`endif

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ADDR_W'(int'(y) * MAP_W + int'(x));
    endfunction

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (int'(x) < MAP_W) && (int'(y) < MAP_H);
    endfunction

    logic [1:0]          state_r;
    logic [1:0]          next_s;
    logic                ready_r;
    logic [2:0]          mem_type_r  [N_TILES];
    logic [STATE_W-1:0]  mem_state_r [N_TILES];

    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [2:0]          wr_type_s;
    logic [STATE_W-1:0]  wr_state_s;

    logic [COORD_W-1:0]  init_x_s;
    logic [COORD_W-1:0]  init_y_s;
    tile_t               init_tile_s;
    logic                init_last_s;
    logic                init_step_s;

    assign init_step_s = (state_r == ST_INIT) && !reload_i;

    map_init_seq #(
        .MAP_W   (MAP_W),
        .MAP_H   (MAP_H),
        .COORD_W (COORD_W)
    ) u_init_seq (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (reload_i),
        .step  (init_step_s),
        .x     (init_x_s),
        .y     (init_y_s),
        .tile  (init_tile_s),
        .last  (init_last_s)
    );

`ifdef MAP_DAMAGE_EN
    logic [COORD_W-1:0]  hit_x_r;
    logic [COORD_W-1:0]  hit_y_r;
    logic                hit_wr_r;
    logic [2:0]          hit_new_type_r;
    logic [STATE_W-1:0]  hit_new_state_r;
    logic                hit_done_r;
    logic [1:0]          hit_result_r;
    logic                hit_ready_r;
    logic [ADDR_W-1:0]   hit_addr_s;
    logic                calc_wr_s;
    logic [2:0]          calc_type_s;
    logic [STATE_W-1:0]  calc_state_s;
    logic [1:0]          calc_result_s;

    assign hit_addr_s = tile_addr(hit_x_r, hit_y_r);

    // Damage rules applied to the latched tile during HIT_RD
    always_comb begin
        calc_wr_s     = 1'b0;
        calc_type_s   = mem_type_r[hit_addr_s];
        calc_state_s  = mem_state_r[hit_addr_s];
        calc_result_s = HR_ABSORB;
        if (!in_range(hit_x_r, hit_y_r)) begin
            calc_result_s = HR_ABSORB;
        end else begin
            case (block_type_e'(mem_type_r[hit_addr_s]))
                BT_BRICK: begin
                    calc_wr_s = 1'b1;
                    if (mem_state_r[hit_addr_s] > STATE_W'(1'b1)) begin
                        calc_state_s  = mem_state_r[hit_addr_s] - 1'b1;
                        calc_result_s = HR_ABSORB;
                    end else begin
                        calc_type_s   = BT_AIR;
                        calc_state_s  = {STATE_W{1'b0}};
                        calc_result_s = HR_DESTROY;
                    end
                end
                BT_WALL: calc_result_s = HR_ABSORB;
                default: calc_result_s = HR_PASS;
            endcase
        end
    end

    // Hit pipeline: latch on accept, evaluate in HIT_RD, write in HIT_WR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_x_r         <= {COORD_W{1'b0}};
            hit_y_r         <= {COORD_W{1'b0}};
            hit_wr_r        <= 1'b0;
            hit_new_type_r  <= 3'd0;
            hit_new_state_r <= {STATE_W{1'b0}};
            hit_done_r      <= 1'b0;
            hit_result_r    <= 2'd0;
        end else begin
            hit_done_r <= 1'b0;
            if (reload_i) begin
                hit_wr_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (hit_valid_i) begin
                            hit_x_r <= hit_x_i;
                            hit_y_r <= hit_y_i;
                        end else begin
                            hit_x_r <= hit_x_r;
                        end
                    end
                    ST_HIT_RD: begin
                        hit_wr_r        <= calc_wr_s;
                        hit_new_type_r  <= calc_type_s;
                        hit_new_state_r <= calc_state_s;
                        hit_done_r      <= 1'b1;
                        hit_result_r    <= calc_result_s;
                    end
                    default: hit_wr_r <= hit_wr_r;
                endcase
            end
        end
    end

    assign hit_ready_o  = hit_ready_r;
    assign hit_done_o   = hit_done_r;
    assign hit_result_o = hit_result_r;
`else
    logic unused_hit_s;
    assign unused_hit_s = ^{hit_valid_i, hit_x_i, hit_y_i};
    assign hit_ready_o  = 1'b0;
    assign hit_done_o   = 1'b0;
    assign hit_result_o = 2'd0;
`endif

    // Next-state selection; reload wins over everything, including a new hit
    always_comb begin
        next_s = state_r;
        if (reload_i) begin
            next_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_last_s) next_s = ST_IDLE;
                    else             next_s = ST_INIT;
                end
`ifdef MAP_DAMAGE_EN
                ST_IDLE: begin
                    if (hit_valid_i) next_s = ST_HIT_RD;
                    else             next_s = ST_IDLE;
                end
                ST_HIT_RD: next_s = ST_HIT_WR;
                ST_HIT_WR: next_s = ST_IDLE;
`else
                ST_IDLE: next_s = ST_IDLE;
`endif
                default: next_s = ST_INIT;
            endcase
        end
    end

    // FSM state and the registered status flags derived from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_INIT;
            ready_r <= 1'b0;
`ifdef MAP_DAMAGE_EN
            hit_ready_r <= 1'b0;
`endif
        end else begin
            state_r <= next_s;
            ready_r <= (next_s != ST_INIT);
`ifdef MAP_DAMAGE_EN
            hit_ready_r <= (next_s == ST_IDLE);
`endif
        end
    end

    assign ready_o = ready_r;

    // Single write port shared by the rebuild walker and the damage path
    always_comb begin
        wr_en_s    = 1'b0;
        wr_addr_s  = tile_addr(init_x_s, init_y_s);
        wr_type_s  = init_tile_s.btype;
        wr_state_s = {STATE_W{&init_tile_s.state}};
        if (reload_i) begin
            wr_en_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            wr_en_s = 1'b1;
`ifdef MAP_DAMAGE_EN
        end else if (state_r == ST_HIT_WR && hit_wr_r) begin
            wr_en_s    = 1'b1;
            wr_addr_s  = hit_addr_s;
            wr_type_s  = hit_new_type_r;
            wr_state_s = hit_new_state_r;
`endif
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Tile storage; contents are rebuilt after reset, so no reset here
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_type_r[wr_addr_s]  <= wr_type_s;
            mem_state_r[wr_addr_s] <= wr_state_s;
        end
    end

    for (genvar ch = 0; ch < N_RD; ch++) begin : g_rd
        logic [COORD_W-1:0] x_s;
        logic [COORD_W-1:0] y_s;
        logic [2:0]         type_r;
        logic [STATE_W-1:0] state_r;

        assign x_s = rd_x_i[ch*COORD_W +: COORD_W];
        assign y_s = rd_y_i[ch*COORD_W +: COORD_W];

        // Registered read channel; returns pre-write data on a same-cycle write
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                type_r  <= BT_AIR;
                state_r <= {STATE_W{1'b0}};
            end else if (!rd_en_i[ch] || (this_state_init())) begin
                type_r  <= BT_AIR;
                state_r <= {STATE_W{1'b0}};
            end else if (!in_range(x_s, y_s)) begin
                type_r  <= BT_WALL;
                state_r <= {STATE_W{1'b1}};
            end else begin
                type_r  <= mem_type_r[tile_addr(x_s, y_s)];
                state_r <= mem_state_r[tile_addr(x_s, y_s)];
            end
        end

        assign rd_type_o[ch*3 +: 3]             = type_r;
        assign rd_state_o[ch*STATE_W +: STATE_W] = state_r;
    end

    function automatic logic this_state_init();
        return (state_r == ST_INIT);
    endfunction

endmodule

// File: tb/tb_map_tile_ram.sv
// Self-checking bench for map_tile_ram; adapts its hit expectations to
// whether MAP_DAMAGE_EN is defined for the build.
module tb_map_tile_ram;

    localparam logic [2:0] T_BRICK = 3'd0;
    localparam logic [2:0] T_WALL  = 3'd1;
    localparam logic [2:0] T_AIR   = 3'd7;
    localparam logic [1:0] R_PASS    = 2'd0;
    localparam logic [1:0] R_ABSORB  = 2'd1;
    localparam logic [1:0] R_DESTROY = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       reload;
    logic       ready;
    logic [1:0] rd_en;
    logic [7:0] rd_x;
    logic [7:0] rd_y;
    logic [5:0] rd_type;
    logic [7:0] rd_state;
    logic       hit_valid;
    logic [3:0] hit_x;
    logic [3:0] hit_y;
    logic       hit_ready;
    logic       hit_done;
    logic [1:0] hit_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         ch;
        bit         en;
        int         x;
        int         y;
        logic [2:0] et;
        logic [3:0] es;
        string      nm;
    } rd_vec_t;

    typedef struct {
        int         ch;
        logic [6:0] exp;
        string      nm;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] hit_q[$];
    rd_vec_t    vecs[$];

    map_tile_ram dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reload_i     (reload),
        .ready_o      (ready),
        .rd_en_i      (rd_en),
        .rd_x_i       (rd_x),
        .rd_y_i       (rd_y),
        .rd_type_o    (rd_type),
        .rd_state_o   (rd_state),
        .hit_valid_i  (hit_valid),
        .hit_x_i      (hit_x),
        .hit_y_i      (hit_y),
        .hit_ready_o  (hit_ready),
        .hit_done_o   (hit_done),
        .hit_result_o (hit_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd_cycle(input int ch, input bit en, input int x, input int y,
                            input logic [2:0] et, input logic [3:0] es, input string nm);
        rd_exp_t e;
        @(negedge clk);
        rd_en               = 2'b00;
        rd_en[ch]           = en;
        rd_x[ch*4 +: 4]     = 4'(x);
        rd_y[ch*4 +: 4]     = 4'(y);
        e.ch  = ch;
        e.exp = {et, es};
        e.nm  = nm;
        rd_q.push_back(e);
        @(posedge clk); #1;
        e = rd_q.pop_front();
        check(e.nm, {25'd0, rd_type[e.ch*3 +: 3], rd_state[e.ch*4 +: 4]}, {25'd0, e.exp});
    endtask

    task automatic wait_ready(input int exp_cycles, input string nm);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, n, exp_cycles);
    endtask

`ifdef MAP_DAMAGE_EN
    task automatic do_hit(input int x, input int y, input logic [1:0] exp, input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (!hit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ready"}, {31'd0, hit_ready}, 32'd1);
        hit_valid = 1'b1;
        hit_x     = 4'(x);
        hit_y     = 4'(y);
        hit_q.push_back(exp);
        @(posedge clk); #1;
        hit_valid = 1'b0;
        n = 0;
        while (!hit_done && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, " latency"}, n, 32'd1);
        check({nm, " result"}, {30'd0, hit_result}, {30'd0, hit_q.pop_front()});
        @(posedge clk); #1;
        check({nm, " pulse"}, {31'd0, hit_done}, 32'd0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_done;
        rst       = 1'b1;
        reload    = 1'b0;
        rd_en     = 2'b00;
        rd_x      = 8'd0;
        rd_y      = 8'd0;
        hit_valid = 1'b0;
        hit_x     = 4'd0;
        hit_y     = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst ready", {31'd0, ready}, 32'd0);
        check("rst hit_ready", {31'd0, hit_ready}, 32'd0);
        check("rst hit_done", {31'd0, hit_done}, 32'd0);
        check("rst hit_result", {30'd0, hit_result}, 32'd0);
        check("rst rd ch0", {25'd0, rd_type[2:0], rd_state[3:0]}, {25'd0, T_AIR, 4'h0});
        check("rst rd ch1", {25'd0, rd_type[5:3], rd_state[7:4]}, {25'd0, T_AIR, 4'h0});

        @(negedge clk);
        rst = 1'b0;
        wait_ready(169, "init length");
`ifdef MAP_DAMAGE_EN
        check("hit_ready after init", {31'd0, hit_ready}, 32'd1);
`else
        check("hit_ready tied", {31'd0, hit_ready}, 32'd0);
`endif

        vecs.push_back('{0, 1'b1, 1, 1, T_BRICK, 4'hF, "rd (1,1)"});
        vecs.push_back('{0, 1'b1, 0, 6, T_WALL, 4'hF, "rd (0,6)"});
        vecs.push_back('{0, 1'b1, 6, 5, T_AIR, 4'hF, "rd (6,5)"});
        vecs.push_back('{1, 1'b1, 13, 2, T_WALL, 4'hF, "rd oor (13,2)"});
        vecs.push_back('{0, 1'b0, 1, 1, T_AIR, 4'h0, "rd disabled"});
        vecs.push_back('{1, 1'b1, 12, 6, T_WALL, 4'hF, "rd (12,6)"});
        vecs.push_back('{1, 1'b1, 2, 6, T_BRICK, 4'hF, "rd (2,6)"});
        vecs.push_back('{1, 1'b1, 3, 6, T_BRICK, 4'hF, "rd (3,6)"});
        vecs.push_back('{1, 1'b1, 9, 6, T_BRICK, 4'hF, "rd (9,6)"});
        vecs.push_back('{1, 1'b1, 10, 6, T_BRICK, 4'hF, "rd (10,6)"});
        vecs.push_back('{1, 1'b1, 4, 6, T_AIR, 4'hF, "rd (4,6)"});
        vecs.push_back('{0, 1'b1, 11, 6, T_AIR, 4'hF, "rd (11,6)"});
        vecs.push_back('{0, 1'b1, 0, 0, T_AIR, 4'hF, "rd (0,0)"});
        vecs.push_back('{0, 1'b1, 12, 12, T_AIR, 4'hF, "rd (12,12)"});
        vecs.push_back('{0, 1'b1, 5, 7, T_AIR, 4'hF, "rd (5,7)"});
        vecs.push_back('{0, 1'b1, 2, 2, T_AIR, 4'hF, "rd (2,2)"});
        vecs.push_back('{1, 1'b1, 11, 11, T_BRICK, 4'hF, "rd (11,11)"});
        vecs.push_back('{0, 1'b1, 15, 15, T_WALL, 4'hF, "rd oor (15,15)"});
        vecs.push_back('{1, 1'b1, 0, 13, T_WALL, 4'hF, "rd oor (0,13)"});
        for (int i = 0; i < vecs.size(); i++) begin
            rd_cycle(vecs[i].ch, vecs[i].en, vecs[i].x, vecs[i].y, vecs[i].et, vecs[i].es, vecs[i].nm);
        end

`ifdef MAP_DAMAGE_EN
        for (int i = 0; i < 15; i++) begin
            do_hit(1, 1, (i < 14) ? R_ABSORB : R_DESTROY, $sformatf("hit (1,1) #%0d", i));
        end
        rd_cycle(0, 1'b1, 1, 1, T_AIR, 4'h0, "rd destroyed (1,1)");
        do_hit(0, 6, R_ABSORB, "hit wall (0,6)");
        rd_cycle(0, 1'b1, 0, 6, T_WALL, 4'hF, "rd wall after hit");
        do_hit(0, 0, R_PASS, "hit air (0,0)");
        rd_cycle(1, 1'b1, 0, 0, T_AIR, 4'hF, "rd air after hit");
        do_hit(14, 3, R_ABSORB, "hit oor (14,3)");

        // Read racing the HIT_WR write of the same tile
        @(negedge clk);
        n = 0;
        while (!hit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        hit_valid = 1'b1;
        hit_x     = 4'd3;
        hit_y     = 4'd1;
        hit_q.push_back(R_ABSORB);
        @(posedge clk); #1;
        hit_valid = 1'b0;
        @(posedge clk); #1;
        check("race done", {31'd0, hit_done}, 32'd1);
        check("race result", {30'd0, hit_result}, {30'd0, hit_q.pop_front()});
        @(negedge clk);
        rd_en    = 2'b01;
        rd_x     = 8'h03;
        rd_y     = 8'h01;
        rd_q.push_back('{0, {T_BRICK, 4'hF}, "race pre-write"});
        rd_q.push_back('{0, {T_BRICK, 4'hE}, "race post-write"});
        for (int i = 0; i < 2; i++) begin
            rd_exp_t e;
            @(posedge clk); #1;
            e = rd_q.pop_front();
            check(e.nm, {25'd0, rd_type[2:0], rd_state[3:0]}, {25'd0, e.exp});
        end
        rd_en = 2'b00;
`else
        @(negedge clk);
        hit_valid = 1'b1;
        hit_x     = 4'd1;
        hit_y     = 4'd1;
        saw_done  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (hit_ready || hit_done || hit_result != 2'd0) saw_done = 1'b1;
        end
        check("hit port inert", {31'd0, saw_done}, 32'd0);
        hit_valid = 1'b0;
        rd_cycle(0, 1'b1, 1, 1, T_BRICK, 4'hF, "rd read-only (1,1)");
`endif

        // Reload, optionally discarding an accepted hit, then rebuild
        @(negedge clk);
`ifdef MAP_DAMAGE_EN
        n = 0;
        while (!hit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        hit_valid = 1'b1;
        hit_x     = 4'd5;
        hit_y     = 4'd3;
        @(posedge clk); #1;
        hit_valid = 1'b0;
        @(negedge clk);
`endif
        reload   = 1'b1;
        rd_en    = 2'b10;
        rd_x     = 8'h10;
        rd_y     = 8'h10;
        @(posedge clk); #1;
        reload = 1'b0;
        check("reload ready low", {31'd0, ready}, 32'd0);
        saw_done = hit_done;
        n = 0;
        while (!ready && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (hit_done) saw_done = 1'b1;
            if (n == 10) begin
                check("rd during init", {25'd0, rd_type[5:3], rd_state[7:4]}, {25'd0, T_AIR, 4'h0});
            end
        end
        check("reload length", n, 32'd169);
        check("reload no hit_done", {31'd0, saw_done}, 32'd0);
        rd_cycle(1, 1'b1, 1, 1, T_BRICK, 4'hF, "rd restored (1,1)");
        rd_cycle(1, 1'b1, 5, 3, T_BRICK, 4'hF, "rd untouched (5,3)");
        rd_cycle(0, 1'b1, 3, 1, T_BRICK, 4'hF, "rd restored (3,1)");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_tile_ram.md
# map_tile_ram

Parametrised, writable successor to the fixed tile map. It holds a MAP_W x MAP_H grid of {type, state} tiles, serves N_RD independent registered read channels (renderer, tank collision, bullet collision) and applies bullet damage through a read-modify-write handshake. It rebuilds the default layout on reset or on request. It sits between the game-logic blocks and the VGA tile renderer.

## Interface
- MAP_W, 13, columns
- MAP_H, 13, rows
- COORD_W, 4, coordinate width; must satisfy 2^COORD_W >= max(MAP_W, MAP_H)
- STATE_W, 4, per-tile state (hit points) width
- N_RD, 2, number of read channels
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- reload_i  in  1  single-cycle request to rebuild the default layout
- ready_o  out  1  high when the map is loaded and idle-capable; low during INIT
- rd_en_i  in  N_RD  per-channel read enable
- rd_x_i, rd_y_i  in  N_RD*COORD_W each  per-channel coordinates
- rd_type_o  out  N_RD*3  per-channel block type
- rd_state_o  out  N_RD*STATE_W  per-channel block state
- hit_valid_i  in  1  damage request
- hit_x_i, hit_y_i  in  COORD_W each  damage coordinates
- hit_ready_o  out  1  damage request accepted when valid && ready
- hit_done_o  out  1  one-cycle completion pulse
- hit_result_o  out  2  PASS=0, ABSORB=1, DESTROY=2; valid with hit_done_o

## Operation
- Type encoding: BRICK=0, WALL=1, TREE=2, WATER=3, AIR=7.
- Default layout, evaluated per tile by the package function default_tile(x,y), with mid = MAP_H/2:
  - rows 0, mid-1, mid+1 and MAP_H-1: AIR.
  - row mid: WALL at x=0 and x=MAP_W-1; BRICK at x=2, 3, MAP_W-4 and MAP_W-3; AIR elsewhere.
  - all other rows: BRICK at odd x, AIR at even x.
  - state field is all-ones for every tile.
- Main FSM states: INIT, IDLE, HIT_RD, HIT_WR.
- INIT:
  - writes one tile per cycle in raster order (x fastest), MAP_W*MAP_H cycles, then enters IDLE.
  - ready_o and hit_ready_o are 0 throughout.
- IDLE:
  - hit_ready_o = 1.
  - an accepted hit latches the coordinates and moves to HIT_RD.
- HIT_RD: reads the latched tile, then moves to HIT_WR.
- HIT_WR applies the damage, pulses hit_done_o and returns to IDLE:
  - BRICK with state > 1: state - 1, ABSORB.
  - BRICK with state == 1: tile becomes {AIR, 0}, DESTROY.
  - WALL: unchanged, ABSORB.
  - TREE, WATER, AIR: unchanged, PASS.
  - out-of-range coordinates: no write, ABSORB.
- Read channels:
  - enable low: the next cycle outputs {AIR, 0}.
  - out-of-range coordinates: {WALL, all-ones}.
  - during INIT: {AIR, 0}.
  - otherwise: the tile contents.
- reload_i from any state enters INIT on the next cycle. An in-flight hit is discarded with no hit_done_o. reload_i has priority over a same-cycle hit_valid_i, which is not accepted.

## Timing
- Reset values:
  - FSM = INIT, init counter = 0.
  - ready_o = 0, hit_ready_o = 0, hit_done_o = 0, hit_result_o = 0.
  - every read output = {AIR, 0}.
- Read latency is 1 cycle. A read in the same cycle as an HIT_WR write returns the pre-write value. The next cycle returns the new value.
- Hit latency: accept in cycle N, hit_done_o in cycle N+2. Maximum throughput is one hit every 3 cycles.
- ready_o rises in the cycle after the last INIT write.
- State arithmetic is unsigned STATE_W bits. Decrement never wraps, because state 1 is converted to AIR.

## Configuration
- MAP_DAMAGE_EN:
  - defined: the hit port and the HIT_RD/HIT_WR states are present.
  - undefined: the map is read-only after INIT. hit_ready_o is tied 0 and hit_done_o and hit_result_o are tied 0. The FSM reduces to INIT and IDLE.

## Structure
- Package map_pkg holds:
  - the block_type_e enum and the hit_result_e enum.
  - the tile_t struct {type, state}.
  - the default_tile() function.
- Sub-module map_init_seq is the INIT raster counter. It generates the write address and tile, and raises done.

## Test plan
- Reset released with MAP 13x13 -> ready_o rises after 169 cycles. Channel 0 reads (1,1) -> {BRICK, 4'hF}; (0,6) -> {WALL, 4'hF}; (6,5) -> {AIR, 4'hF}.
- 15 hits on (1,1) -> results are 14 x ABSORB then DESTROY. A subsequent read of (1,1) -> {AIR, 0}.
- Hit on (0,6) -> ABSORB, tile unchanged. Hit on (0,0) -> PASS.
- Channel 1 reads (13,2) -> {WALL, 4'hF}. Channel 0 reads with rd_en_i=0 -> {AIR, 0}.
- Hit accepted, then reload_i in the next cycle -> no hit_done_o, ready_o low for 169 cycles, and (1,1) restored to {BRICK, 4'hF}.
- Channel 0 reads (3,1) in the HIT_WR cycle of a hit on (3,1) -> returns {BRICK, F}. The next cycle returns {BRICK, E}.
